// File: rtl/sprite_loader.sv
// sprite_loader: byte-stream command parser driving per-object sprite load strobes.
// Keeps a shadow x/y per object so pixel writes go out as absolute coordinates.
module sprite_loader #(
    parameter int unsigned N_OBJ = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N_OBJ-1:0] setxy,
    output logic [N_OBJ-1:0] setshape,
    output logic [N_OBJ-1:0] change_pxl,
    output logic [9:0]       new_x,
    output logic [9:0]       new_y,
    output logic [63:0]      new_shape,
    output logic [23:0]      pix,
    output logic             busy,
    output logic             err
);

    localparam int unsigned IDW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    localparam logic [2:0] OP_SETXY    = 3'd1;
    localparam logic [2:0] OP_SETSHAPE = 3'd2;
    localparam logic [2:0] OP_PIXEL    = 3'd3;
    localparam logic [2:0] OP_FILL     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OBJ,
        S_ARGS,
        S_EXEC,
        S_FILL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op;
    logic [3:0]       id;
    logic [3:0]       arg_cnt;
    logic [55:0]      arg_sr;
    logic [5:0]       fill_addr;
    logic [9:0]       shadow_x [N_OBJ];
    logic [9:0]       shadow_y [N_OBJ];

    logic             accept;
    logic             known_op;
    logic             id_ok;
    logic             last_arg;
    logic [3:0]       arg_need;
    logic [IDW-1:0]   id_idx;
    logic [N_OBJ-1:0] onehot;
    logic [63:0]      args_full;
    logic [9:0]       cur_x;
    logic [9:0]       cur_y;
    logic [5:0]       fill_nxt;

    // Decode of the current byte, latched command and shadow lookup
    always_comb begin
        accept    = in_valid & in_ready;
        known_op  = (in_data >= 8'd1) && (in_data <= 8'd4);
        id_ok     = 32'(id) < N_OBJ;
        id_idx    = id[IDW-1:0];
        onehot    = N_OBJ'(1) << id_idx;
        args_full = {arg_sr, in_data};
        cur_x     = shadow_x[id_idx];
        cur_y     = shadow_y[id_idx];
        fill_nxt  = fill_addr + 6'd1;
        case (op)
            OP_SETXY:    arg_need = 4'd4;
            OP_SETSHAPE: arg_need = 4'd8;
            OP_PIXEL:    arg_need = 4'd4;
            OP_FILL:     arg_need = 4'd3;
            default:     arg_need = 4'd4;
        endcase
        last_arg = accept && (state == S_ARGS) && (arg_cnt == arg_need - 4'd1);
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && known_op) state_nxt = S_OBJ;
            S_OBJ:  if (accept) state_nxt = S_ARGS;
            S_ARGS: if (last_arg) state_nxt = (op == OP_FILL && id_ok) ? S_FILL : S_EXEC;
            S_EXEC: state_nxt = S_IDLE;
            S_FILL: if (fill_addr == 6'd63) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, handshake, strobes, data buses and shadow table
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            setxy      <= '0;
            setshape   <= '0;
            change_pxl <= '0;
            new_x      <= '0;
            new_y      <= '0;
            new_shape  <= '0;
            pix        <= '0;
            op         <= '0;
            id         <= '0;
            arg_cnt    <= '0;
            arg_sr     <= '0;
            fill_addr  <= '0;
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                shadow_x[i] <= '0;
                shadow_y[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            in_ready   <= state_nxt inside {S_IDLE, S_OBJ, S_ARGS};
            busy       <= state_nxt != S_IDLE;
            err        <= 1'b0;
            setxy      <= '0;
            setshape   <= '0;
            change_pxl <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (known_op) begin
                            op      <= in_data[2:0];
                            arg_cnt <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_OBJ: begin
                    if (accept) id <= in_data[3:0];
                end
                S_ARGS: begin
                    if (accept) begin
                        arg_sr  <= args_full[55:0];
                        arg_cnt <= arg_cnt + 4'd1;
                    end
                    if (last_arg) begin
                        if (!id_ok) begin
                            err <= 1'b1;
                        end else begin
                            case (op)
                                OP_SETXY: begin
                                    setxy            <= onehot;
                                    new_x            <= {args_full[25:24], args_full[23:16]};
                                    new_y            <= {args_full[9:8], args_full[7:0]};
                                    shadow_x[id_idx] <= {args_full[25:24], args_full[23:16]};
                                    shadow_y[id_idx] <= {args_full[9:8], args_full[7:0]};
                                end
                                OP_SETSHAPE: begin
                                    setshape  <= onehot;
                                    new_shape <= args_full;
                                end
                                OP_PIXEL: begin
                                    change_pxl <= onehot;
                                    new_x      <= cur_x + 10'(args_full[26:24]);
                                    new_y      <= cur_y + 10'(args_full[29:27]);
                                    pix        <= args_full[23:0];
                                end
                                OP_FILL: begin
                                    change_pxl <= onehot;
                                    new_x      <= cur_x;
                                    new_y      <= cur_y;
                                    pix        <= args_full[23:0];
                                    fill_addr  <= '0;
                                end
                                default: err <= 1'b1;
                            endcase
                        end
                    end
                end
                S_FILL: begin
                    // fill_addr is the address shown on the bus this cycle
                    if (fill_addr != 6'd63) begin
                        fill_addr  <= fill_nxt;
                        change_pxl <= onehot;
                        new_x      <= cur_x + 10'(fill_nxt[2:0]);
                        new_y      <= cur_y + 10'(fill_nxt[5:3]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: stimulus pushes expected strobe events,
// a negedge monitor pops and compares whenever a strobe or err is seen.
module tb_sprite_loader;

    localparam int unsigned N_OBJ = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N_OBJ-1:0] setxy;
    logic [N_OBJ-1:0] setshape;
    logic [N_OBJ-1:0] change_pxl;
    logic [9:0]       new_x;
    logic [9:0]       new_y;
    logic [63:0]      new_shape;
    logic [23:0]      pix;
    logic             busy;
    logic             err;

    sprite_loader #(.N_OBJ(N_OBJ)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .setxy      (setxy),
        .setshape   (setshape),
        .change_pxl (change_pxl),
        .new_x      (new_x),
        .new_y      (new_y),
        .new_shape  (new_shape),
        .pix        (pix),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // kind: 0 setxy, 1 setshape, 2 change_pxl, 3 err
    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  vec;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [63:0] shape;
        logic [23:0] p;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] byte_q[$];
    int         total = 0;
    int         bad = 0;
    int         gap = 0;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_ev(input logic [1:0] k, input int obj, input logic [9:0] x,
                           input logic [9:0] y, input logic [63:0] sh, input logic [23:0] p);
        ev_t e;
        e.kind  = k;
        e.vec   = 8'd0;
        if (obj >= 0) e.vec = 8'd1 << obj;
        e.x     = x;
        e.y     = y;
        e.shape = sh;
        e.p     = p;
        exp_q.push_back(e);
    endtask

    // Sends every byte in byte_q, holding each until accepted, with optional idle gaps
    task automatic send_all();
        logic [7:0] b;
        logic       r;
        bit         got;
        while (byte_q.size() > 0) begin
            b        = byte_q.pop_front();
            in_valid = 1'b1;
            in_data  = b;
            got      = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                r = in_ready;
                @(posedge clk);
                if (r) got = 1'b1;
            end
            #1;
            in_valid = 1'b0;
            if (!got) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: byte %0h not accepted within 200 cycles", b);
            end
            if (byte_q.size() > 0 && gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: compares each observed strobe/err against the scoreboard head
    always @(negedge clk) begin
        int   n;
        ev_t  e;
        logic [1:0] k;
        logic [7:0] v;
        bit   ok;
        if (mon_en) begin
            n = $countones(setxy) + $countones(setshape) + $countones(change_pxl) + int'(err);
            if (n > 1) begin
                total++;
                bad++;
                $display("FAIL strobe_exclusive: %0d strobes/err high at once", n);
            end else if (n == 1) begin
                if (setxy != 0)         begin k = 2'd0; v = setxy;      end
                else if (setshape != 0) begin k = 2'd1; v = setshape;   end
                else if (change_pxl != 0) begin k = 2'd2; v = change_pxl; end
                else                    begin k = 2'd3; v = 8'd0;       end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: kind=%0d vec=%b x=%0d y=%0d with no expectation",
                             k, v, new_x, new_y);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (k == e.kind) && (v == e.vec);
                    if (k == 2'd0) ok = ok && (new_x == e.x) && (new_y == e.y);
                    if (k == 2'd1) ok = ok && (new_shape == e.shape);
                    if (k == 2'd2) ok = ok && (new_x == e.x) && (new_y == e.y) && (pix == e.p);
                    if (!ok) begin
                        bad++;
                        $display("FAIL event: got kind=%0d vec=%b x=%0d y=%0d shape=%h pix=%h expected kind=%0d vec=%b x=%0d y=%0d shape=%h pix=%h",
                                 k, v, new_x, new_y, new_shape, pix,
                                 e.kind, e.vec, e.x, e.y, e.shape, e.p);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rdy_in_reset", 64'(in_ready), 64'd0);
        check("busy_in_reset", 64'(busy), 64'd0);
        check("strobes_in_reset", 64'({setxy, setshape, change_pxl, err}), 64'd0);
        check("buses_in_reset", 64'({new_x, new_y, pix}), 64'd0);
        check("shape_in_reset", new_shape, 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_reset", 64'(in_ready), 64'd1);

        // SETXY obj 2 -> (300,200); in_ready low only in the strobe cycle
        push_ev(2'd0, 2, 10'd300, 10'd200, 64'd0, 24'd0);
        byte_q = '{8'h01, 8'h02, 8'h01, 8'h2C, 8'h00, 8'hC8};
        send_all();
        check("setxy_rdy_low", 64'(in_ready), 64'd0);
        check("setxy_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        check("setxy_rdy_back", 64'(in_ready), 64'd1);
        check("setxy_idle", 64'(busy), 64'd0);

        // PIXEL obj 2, A=0x09 -> (301,201), with gaps between bytes
        push_ev(2'd2, 2, 10'd301, 10'd201, 64'd0, 24'hFF0080);
        gap    = 2;
        byte_q = '{8'h03, 8'h02, 8'h09, 8'hFF, 8'h00, 8'h80};
        send_all();
        gap    = 0;
        repeat (2) @(posedge clk);
        #1;

        // Wrap: obj 0 at x=1020, dx=7 -> x=3
        push_ev(2'd0, 0, 10'd1020, 10'd5, 64'd0, 24'd0);
        byte_q = '{8'h01, 8'h00, 8'h03, 8'hFC, 8'h00, 8'h05};
        send_all();
        push_ev(2'd2, 0, 10'd3, 10'd5, 64'd0, 24'h010203);
        byte_q = '{8'h03, 8'h00, 8'h07, 8'h01, 8'h02, 8'h03};
        send_all();
        repeat (2) @(posedge clk);
        #1;

        // FILL obj 1 at (100,50)
        push_ev(2'd0, 1, 10'd100, 10'd50, 64'd0, 24'd0);
        byte_q = '{8'h01, 8'h01, 8'h00, 8'h64, 8'h00, 8'h32};
        send_all();
        for (int a = 0; a < 64; a++)
            push_ev(2'd2, 1, 10'(100 + (a % 8)), 10'(50 + (a / 8)), 64'd0, 24'h102030);
        byte_q = '{8'h04, 8'h01, 8'h10, 8'h20, 8'h30};
        send_all();
        for (int c = 1; c <= 64; c++) begin
            check("fill_rdy_low", 64'(in_ready), 64'd0);
            check("fill_busy", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
        end
        check("fill_rdy_back", 64'(in_ready), 64'd1);

        // Unknown opcode
        push_ev(2'd3, -1, 10'd0, 10'd0, 64'd0, 24'd0);
        byte_q = '{8'h7F};
        send_all();
        check("badop_rdy_stays", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // SETSHAPE with bad id 9: all 10 bytes consumed, err only
        push_ev(2'd3, -1, 10'd0, 10'd0, 64'd0, 24'd0);
        byte_q = '{8'h02, 8'h09, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_all();
        check("badid_exec_rdy", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("badid_idle_rdy", 64'(in_ready), 64'd1);

        // Reset mid-PIXEL, then a fresh SETSHAPE
        byte_q = '{8'h03, 8'h01, 8'h05};
        send_all();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_cmd_rdy", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_ev(2'd1, 0, 10'd0, 10'd0, 64'hFF00FF00FF00FF00, 24'd0);
        byte_q = '{8'h02, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        send_all();
        repeat (2) @(posedge clk);
        #1;

        // Reset at FILL cycle 20: exactly 20 pulses, then nothing
        push_ev(2'd0, 3, 10'd10, 10'd20, 64'd0, 24'd0);
        byte_q = '{8'h01, 8'h03, 8'h00, 8'h0A, 8'h00, 8'h14};
        send_all();
        for (int a = 0; a < 20; a++)
            push_ev(2'd2, 3, 10'(10 + (a % 8)), 10'(20 + (a / 8)), 64'd0, 24'hAABBCC);
        byte_q = '{8'h04, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        send_all();
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_fill_strobe", 64'(change_pxl), 64'd0);
        check("rst_fill_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        check("rst_fill_drained", 64'(exp_q.size()), 64'd0);

        // Shadow cleared by reset: obj 3 PIXEL A=0x12 lands at (2,2)
        push_ev(2'd2, 3, 10'd2, 10'd2, 64'd0, 24'h010203);
        byte_q = '{8'h03, 8'h03, 8'h12, 8'h01, 8'h02, 8'h03};
        send_all();
        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
